// File: rtl/csi2_packet_sequencer.sv
// csi2_packet_sequencer
//   Packet-level controller for a 2-lane MIPI CSI-2 receive path. Hunts for the
//   HS leader on both lanes, assembles and ECC-checks the packet header, then
//   sequences the long-packet payload and footer. It also produces the
//   frame/line framing pulses, the line and frame counters, and a 16-bit
//   payload stream.
//
//   Ports
//     byte_clk, reset      sole clock; synchronous active-high reset
//     cfg_enable           accept new packets (looked at only while hunting)
//     byte_valid           both lanes in HS, lane bytes valid this cycle
//     lane0/1_byte         deserialized lane bytes (byte n travels on lane n%2)
//     payload_*            {lane1,lane0} beats, byte enables, valid, last beat
//     pkt_dt, pkt_wc       data type / word count of the current or last packet
//     frame_start/end      FS / FE pulses
//     line_start           first payload beat of an image-line packet
//     line_count           image lines in the current frame (saturating)
//     frame_count          completed frames (wrapping)
//     ecc_err, sync_err,
//     trunc_err            error pulses
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   HUNT     | idle, waiting for the leader byte on both lanes
//   HDR_A    | header bytes DI and WC[7:0]
//   HDR_B    | header bytes WC[15:8] and ECC; decode the packet
//   PAYLOAD  | long-packet payload beats, counting down the word count
//   FOOTER   | one cycle of CRC bytes (not checked)
//   WAIT_EOT | discard bytes until the lanes leave HS
module csi2_packet_sequencer #(
    parameter logic [7:0]  SYNC_BYTE  = 8'hB8,
    parameter logic [15:0] MAX_WC     = 16'd8192,
    parameter logic [5:0]  PIX_DT_MIN = 6'h18
) (
    input  logic        byte_clk,
    input  logic        reset,
    input  logic        cfg_enable,
    input  logic        byte_valid,
    input  logic [7:0]  lane0_byte,
    input  logic [7:0]  lane1_byte,
    output logic [15:0] payload_data,
    output logic [1:0]  payload_keep,
    output logic        payload_valid,
    output logic        payload_last,
    output logic [5:0]  pkt_dt,
    output logic [15:0] pkt_wc,
    output logic        frame_start,
    output logic        frame_end,
    output logic        line_start,
    output logic [15:0] line_count,
    output logic [15:0] frame_count,
    output logic        ecc_err,
    output logic        sync_err,
    output logic        trunc_err
);

    typedef enum logic [2:0] {HUNT, HDR_A, HDR_B, PAYLOAD, FOOTER, WAIT_EOT} state_t;

    state_t      state;
    logic [7:0]  hdr_di;
    logic [7:0]  hdr_wc_lo;
    logic [15:0] remaining;

    logic [15:0] hdr_wc;
    logic [23:0] hdr_d;
    logic [5:0]  hdr_dt;
    logic [5:0]  ecc_calc;
    logic        ecc_ok;
    logic        lane0_sync;
    logic        lane1_sync;
    logic        first_beat;

    // In HDR_B the live lane0 byte is WC[15:8] and lane1 carries the ECC.
    assign hdr_wc = {lane0_byte, hdr_wc_lo};
    assign hdr_d  = {hdr_wc, hdr_di};
    assign hdr_dt = hdr_di[5:0];

    assign ecc_calc[0] = hdr_d[0] ^ hdr_d[1] ^ hdr_d[2] ^ hdr_d[4] ^ hdr_d[5] ^ hdr_d[7]
                       ^ hdr_d[10] ^ hdr_d[11] ^ hdr_d[13] ^ hdr_d[16] ^ hdr_d[20]
                       ^ hdr_d[21] ^ hdr_d[22] ^ hdr_d[23];
    assign ecc_calc[1] = hdr_d[0] ^ hdr_d[1] ^ hdr_d[3] ^ hdr_d[4] ^ hdr_d[6] ^ hdr_d[8]
                       ^ hdr_d[10] ^ hdr_d[12] ^ hdr_d[14] ^ hdr_d[17] ^ hdr_d[20]
                       ^ hdr_d[21] ^ hdr_d[22] ^ hdr_d[23];
    assign ecc_calc[2] = hdr_d[0] ^ hdr_d[2] ^ hdr_d[3] ^ hdr_d[5] ^ hdr_d[6] ^ hdr_d[9]
                       ^ hdr_d[11] ^ hdr_d[12] ^ hdr_d[15] ^ hdr_d[18] ^ hdr_d[20]
                       ^ hdr_d[21] ^ hdr_d[22];
    assign ecc_calc[3] = hdr_d[1] ^ hdr_d[2] ^ hdr_d[3] ^ hdr_d[7] ^ hdr_d[8] ^ hdr_d[9]
                       ^ hdr_d[13] ^ hdr_d[14] ^ hdr_d[15] ^ hdr_d[19] ^ hdr_d[20]
                       ^ hdr_d[21] ^ hdr_d[23];
    assign ecc_calc[4] = hdr_d[4] ^ hdr_d[5] ^ hdr_d[6] ^ hdr_d[7] ^ hdr_d[8] ^ hdr_d[9]
                       ^ hdr_d[16] ^ hdr_d[17] ^ hdr_d[18] ^ hdr_d[19] ^ hdr_d[20]
                       ^ hdr_d[22] ^ hdr_d[23];
    assign ecc_calc[5] = hdr_d[10] ^ hdr_d[11] ^ hdr_d[12] ^ hdr_d[13] ^ hdr_d[14] ^ hdr_d[15]
                       ^ hdr_d[16] ^ hdr_d[17] ^ hdr_d[18] ^ hdr_d[19] ^ hdr_d[21]
                       ^ hdr_d[22] ^ hdr_d[23];

    // The two spare ECC bits must be zero; a nonzero value counts as a mismatch.
    assign ecc_ok     = (lane1_byte == {2'b00, ecc_calc});
    assign lane0_sync = (lane0_byte == SYNC_BYTE);
    assign lane1_sync = (lane1_byte == SYNC_BYTE);
    // pkt_wc and remaining are loaded together, so they are equal only on the first beat.
    assign first_beat = (remaining == pkt_wc);

    always_ff @(posedge byte_clk) begin
        if (reset) begin
            state         <= HUNT;
            hdr_di        <= 8'd0;
            hdr_wc_lo     <= 8'd0;
            remaining     <= 16'd0;
            payload_data  <= 16'd0;
            payload_keep  <= 2'b00;
            payload_valid <= 1'b0;
            payload_last  <= 1'b0;
            pkt_dt        <= 6'd0;
            pkt_wc        <= 16'd0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            line_start    <= 1'b0;
            line_count    <= 16'd0;
            frame_count   <= 16'd0;
            ecc_err       <= 1'b0;
            sync_err      <= 1'b0;
            trunc_err     <= 1'b0;
        end else begin
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            line_start    <= 1'b0;
            ecc_err       <= 1'b0;
            sync_err      <= 1'b0;
            trunc_err     <= 1'b0;
            payload_valid <= 1'b0;
            payload_last  <= 1'b0;

            case (state)
                HUNT: begin
                    if (cfg_enable && byte_valid) begin
                        if (lane0_sync && lane1_sync) begin
                            state <= HDR_A;
                        end else if (lane0_sync != lane1_sync) begin
                            sync_err <= 1'b1;
                            state    <= WAIT_EOT;
                        end
                    end
                end

                HDR_A: begin
                    if (!byte_valid) begin
                        state <= HUNT;
                    end else begin
                        hdr_di    <= lane0_byte;
                        hdr_wc_lo <= lane1_byte;
                        state     <= HDR_B;
                    end
                end

                HDR_B: begin
                    if (!byte_valid) begin
                        state <= HUNT;
                    end else if (!ecc_ok) begin
                        ecc_err <= 1'b1;
                        state   <= WAIT_EOT;
                    end else if (hdr_dt < 6'h10) begin
                        pkt_dt <= hdr_dt;
                        if (hdr_dt == 6'h00) begin
                            frame_start <= 1'b1;
                            line_count  <= 16'd0;
                        end
                        if (hdr_dt == 6'h01) begin
                            frame_end   <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end
                        state <= WAIT_EOT;
                    end else if (hdr_wc > MAX_WC) begin
                        trunc_err <= 1'b1;
                        state     <= WAIT_EOT;
                    end else begin
                        pkt_dt    <= hdr_dt;
                        pkt_wc    <= hdr_wc;
                        remaining <= hdr_wc;
                        state     <= (hdr_wc == 16'd0) ? FOOTER : PAYLOAD;
                    end
                end

                PAYLOAD: begin
                    if (!byte_valid) begin
                        trunc_err <= 1'b1;
                        state     <= HUNT;
                    end else begin
                        payload_valid <= 1'b1;
                        payload_data  <= {lane1_byte, lane0_byte};
                        payload_keep  <= (remaining >= 16'd2) ? 2'b11 : 2'b01;
                        payload_last  <= (remaining <= 16'd2);
                        line_start    <= first_beat && (pkt_dt >= PIX_DT_MIN);
                        if (remaining <= 16'd2) begin
                            remaining <= 16'd0;
                            state     <= FOOTER;
                        end else begin
                            remaining <= remaining - 16'd2;
                        end
                    end
                end

                FOOTER: begin
                    if (!byte_valid) begin
                        trunc_err <= 1'b1;
                        state     <= HUNT;
                    end else begin
                        if ((pkt_dt >= PIX_DT_MIN) && (line_count != 16'hFFFF)) begin
                            line_count <= line_count + 16'd1;
                        end
                        state <= WAIT_EOT;
                    end
                end

                WAIT_EOT: begin
                    if (!byte_valid) begin
                        state <= HUNT;
                    end
                end

                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_csi2_packet_sequencer.sv
// Bench for csi2_packet_sequencer: directed packets followed by random packets.
// Each burst is checked against a packet-level reference model.
module tb_csi2_packet_sequencer;

    localparam logic [7:0]  SB  = 8'hB8;
    localparam logic [5:0]  PIX = 6'h18;
    // Syndrome contribution of each header data bit D0..D23.
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    logic        byte_clk = 1'b0;
    logic        reset;
    logic        cfg_enable;
    logic        byte_valid;
    logic [7:0]  lane0_byte;
    logic [7:0]  lane1_byte;
    logic [15:0] payload_data;
    logic [1:0]  payload_keep;
    logic        payload_valid;
    logic        payload_last;
    logic [5:0]  pkt_dt;
    logic [15:0] pkt_wc;
    logic        frame_start;
    logic        frame_end;
    logic        line_start;
    logic [15:0] line_count;
    logic [15:0] frame_count;
    logic        ecc_err;
    logic        sync_err;
    logic        trunc_err;

    csi2_packet_sequencer dut (
        .byte_clk      (byte_clk),
        .reset         (reset),
        .cfg_enable    (cfg_enable),
        .byte_valid    (byte_valid),
        .lane0_byte    (lane0_byte),
        .lane1_byte    (lane1_byte),
        .payload_data  (payload_data),
        .payload_keep  (payload_keep),
        .payload_valid (payload_valid),
        .payload_last  (payload_last),
        .pkt_dt        (pkt_dt),
        .pkt_wc        (pkt_wc),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .line_start    (line_start),
        .line_count    (line_count),
        .frame_count   (frame_count),
        .ecc_err       (ecc_err),
        .sync_err      (sync_err),
        .trunc_err     (trunc_err)
    );

    always #5 byte_clk = ~byte_clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0]  bq [$];
    logic [7:0]  s0 [$];
    logic [7:0]  s1 [$];
    logic        sc [$];

    logic [19:0] exp_beats [$];
    logic [19:0] obs_beats [$];
    int exp_fs, exp_fe, exp_ecc, exp_sync, exp_trunc, exp_ls;
    int obs_fs, obs_fe, obs_ecc, obs_sync, obs_trunc, obs_ls;
    logic [15:0] m_line, m_frame, m_wc;
    logic [5:0]  m_dt;
    logic        mon_en = 1'b0;

    always @(negedge byte_clk) begin
        if (mon_en) begin
            if (payload_valid)
                obs_beats.push_back({payload_data, payload_keep, payload_last, line_start});
            if (frame_start) obs_fs++;
            if (frame_end)   obs_fe++;
            if (ecc_err)     obs_ecc++;
            if (sync_err)    obs_sync++;
            if (trunc_err)   obs_trunc++;
            if (line_start)  obs_ls++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] golden_ecc(input logic [23:0] d);
        logic [5:0] e = 6'd0;
        for (int i = 0; i < 24; i++)
            if (d[i]) e ^= ECC_COL[i];
        return {2'b00, e};
    endfunction

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b, input logic cfg);
        s0.push_back(a);
        s1.push_back(b);
        sc.push_back(cfg);
    endtask

    // Packet as a byte stream: leader, DI, WC_lo, WC_hi, ECC, then ntail bytes.
    task automatic build_pkt(input logic [7:0] di, input logic [15:0] wc,
                             input logic [7:0] ecc_xor, input int ntail, input logic cfg);
        bq.delete();
        bq.push_back(SB);
        bq.push_back(SB);
        bq.push_back(di);
        bq.push_back(wc[7:0]);
        bq.push_back(wc[15:8]);
        bq.push_back(golden_ecc({wc, di}) ^ ecc_xor);
        for (int i = 0; i < ntail; i++) bq.push_back(8'($urandom_range(0, 255)));
        if (bq.size() % 2 != 0) bq.push_back(8'h00);
        for (int i = 0; i < bq.size(); i += 2) push_pair(bq[i], bq[i+1], cfg);
    endtask

    task automatic trunc_to(input int n);
        while (s0.size() > n) begin
            void'(s0.pop_back());
            void'(s1.pop_back());
            void'(sc.pop_back());
        end
    endtask

    // Reference: interpret the burst at packet level.
    task automatic model_run();
        int n;
        int i;
        int nb;
        int first;
        int rem;
        logic [7:0]  di;
        logic [15:0] wc;
        logic [5:0]  dt;
        n = s0.size();
        i = 0;
        exp_fs = 0; exp_fe = 0; exp_ecc = 0; exp_sync = 0; exp_trunc = 0; exp_ls = 0;
        exp_beats.delete();
        while (i < n && !(sc[i] && (s0[i] == SB || s1[i] == SB))) i++;
        if (i >= n) return;
        if (!(s0[i] == SB && s1[i] == SB)) begin
            exp_sync = 1;
            return;
        end
        if (i + 2 >= n) return;
        di = s0[i+1];
        wc = {s0[i+2], s1[i+1]};
        if (s1[i+2] !== golden_ecc({wc, di})) begin
            exp_ecc = 1;
            return;
        end
        dt = di[5:0];
        if (dt < 6'h10) begin
            m_dt = dt;
            if (dt == 6'h00) begin exp_fs = 1; m_line = 16'd0; end
            if (dt == 6'h01) begin exp_fe = 1; m_frame = m_frame + 16'd1; end
            return;
        end
        if (wc > 16'd8192) begin
            exp_trunc = 1;
            return;
        end
        m_dt = dt;
        m_wc = wc;
        nb = (int'(wc) + 1) / 2;
        first = i + 3;
        for (int j = 0; j < nb; j++) begin
            if (first + j >= n) begin
                exp_trunc = 1;
                return;
            end
            rem = int'(wc) - 2 * j;
            exp_beats.push_back({s1[first+j], s0[first+j], (rem >= 2) ? 2'b11 : 2'b01,
                                 (j == nb - 1), (j == 0 && dt >= PIX)});
            if (j == 0 && dt >= PIX) exp_ls = 1;
        end
        if (first + nb >= n) begin
            exp_trunc = 1;
            return;
        end
        if (dt >= PIX && m_line != 16'hFFFF) m_line = m_line + 16'd1;
    endtask

    task automatic run_burst(input string tag);
        model_run();
        obs_fs = 0; obs_fe = 0; obs_ecc = 0; obs_sync = 0; obs_trunc = 0; obs_ls = 0;
        obs_beats.delete();
        mon_en = 1'b1;
        for (int k = 0; k < s0.size(); k++) begin
            @(negedge byte_clk);
            byte_valid = 1'b1;
            lane0_byte = s0[k];
            lane1_byte = s1[k];
            cfg_enable = sc[k];
        end
        @(negedge byte_clk);
        byte_valid = 1'b0;
        lane0_byte = 8'h00;
        lane1_byte = 8'h00;
        repeat (2) @(negedge byte_clk);
        #1 mon_en = 1'b0;
        chk({tag, "/beats"}, obs_beats.size(), exp_beats.size());
        for (int k = 0; k < exp_beats.size(); k++)
            if (k < obs_beats.size())
                chk($sformatf("%s/beat%0d", tag, k), 32'(obs_beats[k]), 32'(exp_beats[k]));
        chk({tag, "/frame_start"}, obs_fs, exp_fs);
        chk({tag, "/frame_end"}, obs_fe, exp_fe);
        chk({tag, "/ecc_err"}, obs_ecc, exp_ecc);
        chk({tag, "/sync_err"}, obs_sync, exp_sync);
        chk({tag, "/trunc_err"}, obs_trunc, exp_trunc);
        chk({tag, "/line_start"}, obs_ls, exp_ls);
        chk({tag, "/line_count"}, line_count, m_line);
        chk({tag, "/frame_count"}, frame_count, m_frame);
        chk({tag, "/pkt_dt"}, pkt_dt, m_dt);
        chk({tag, "/pkt_wc"}, pkt_wc, m_wc);
        s0.delete();
        s1.delete();
        sc.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/payload"}, {payload_data, payload_keep, payload_valid, payload_last}, 32'd0);
        chk({tag, "/pkt"}, {pkt_dt, pkt_wc}, 32'd0);
        chk({tag, "/pulses"}, {frame_start, frame_end, line_start, ecc_err, sync_err, trunc_err}, 32'd0);
        chk({tag, "/counters"}, {line_count, frame_count}, 32'd0);
    endtask

    initial begin
        int kind;
        int wc_r;
        int cut;
        logic [7:0] di_r;
        logic [7:0] ex;
        logic [5:0] dts [6] = '{6'h2A, 6'h2B, 6'h2C, 6'h24, 6'h12, 6'h30};

        reset = 1'b1;
        cfg_enable = 1'b0;
        byte_valid = 1'b0;
        lane0_byte = 8'h00;
        lane1_byte = 8'h00;
        repeat (3) @(negedge byte_clk);
        check_zero("reset");
        reset = 1'b0;
        cfg_enable = 1'b1;
        m_line = 16'd0; m_frame = 16'd0; m_wc = 16'd0; m_dt = 6'd0;
        @(negedge byte_clk);
        #1;

        build_pkt(8'h00, 16'd0, 8'h00, 0, 1'b1);
        run_burst("fs");

        push_pair(SB, SB, 1'b1);
        push_pair(8'h01, 8'h00, 1'b1);
        push_pair(8'h00, 8'h07, 1'b1);
        run_burst("fe");

        push_pair(SB, SB, 1'b1);
        push_pair(8'h01, 8'h00, 1'b1);
        push_pair(8'h00, 8'h06, 1'b1);
        run_burst("fe_bad_ecc");

        build_pkt(8'h00, 16'd0, 8'h00, 0, 1'b1);
        run_burst("fs2");

        build_pkt(8'h2B, 16'd5, 8'h00, 7, 1'b1);
        run_burst("raw10_wc5");

        build_pkt(8'h2A, 16'd4, 8'h00, 6, 1'b1);
        run_burst("raw8_wc4");

        build_pkt(8'h2B, 16'd9000, 8'h00, 4, 1'b1);
        run_burst("wc_over");

        build_pkt(8'h2B, 16'd6, 8'h00, 8, 1'b1);
        trunc_to(4);
        run_burst("trunc_beat1");

        push_pair(SB, 8'h00, 1'b1);
        build_pkt(8'h00, 16'd0, 8'h00, 0, 1'b1);
        run_burst("sync_err");

        build_pkt(8'h2A, 16'd4, 8'h00, 6, 1'b1);
        for (int k = 1; k < sc.size(); k++) sc[k] = 1'b0;
        run_burst("cfg_drop_mid");

        build_pkt(8'h00, 16'd0, 8'h00, 0, 1'b0);
        run_burst("cfg_off");

        build_pkt(8'h00, 16'd0, 8'h00, 0, 1'b1);
        run_burst("fs_no_fe");

        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 9);
            ex = ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            if (kind == 0) begin
                build_pkt(8'h00, 16'($urandom_range(0, 65535)), ex, 0, 1'b1);
            end else if (kind == 1) begin
                build_pkt(8'h01, 16'($urandom_range(0, 65535)), ex, 0, 1'b1);
            end else if (kind == 2) begin
                build_pkt({2'($urandom_range(0, 3)), 6'h2B}, 16'd8193, ex, 4, 1'b1);
            end else begin
                di_r = {2'($urandom_range(0, 3)), dts[$urandom_range(0, 5)]};
                wc_r = $urandom_range(1, 24);
                build_pkt(di_r, 16'(wc_r), ex, wc_r + 2, 1'b1);
            end
            if ($urandom_range(0, 6) == 0) begin
                cut = $urandom_range(1, s0.size());
                trunc_to(cut);
            end
            run_burst($sformatf("rand%0d", r));
        end

        build_pkt(8'h2B, 16'd8, 8'h00, 10, 1'b1);
        run_burst("pre_reset_line");

        build_pkt(8'h2B, 16'd10, 8'h00, 12, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge byte_clk);
            byte_valid = 1'b1;
            lane0_byte = s0[k];
            lane1_byte = s1[k];
            cfg_enable = 1'b1;
        end
        @(negedge byte_clk);
        chk("mid_payload/valid", payload_valid, 1'b1);
        lane0_byte = s0[5];
        lane1_byte = s1[5];
        reset = 1'b1;
        @(negedge byte_clk);
        check_zero("mid_reset");
        reset = 1'b0;
        byte_valid = 1'b0;
        lane0_byte = 8'h00;
        lane1_byte = 8'h00;
        s0.delete();
        s1.delete();
        sc.delete();
        m_line = 16'd0; m_frame = 16'd0; m_wc = 16'd0; m_dt = 6'd0;
        repeat (2) @(negedge byte_clk);
        #1;

        build_pkt(8'h00, 16'd0, 8'h00, 0, 1'b1);
        run_burst("fs_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/csi2_packet_sequencer.md
Name: csi2_packet_sequencer

Overview:
- Packet-level controller for the 2-lane MIPI CSI-2 receive path.
- Consumes per-lane deserialized bytes in the byte_clk domain.
- Hunts for HS sync and assembles and ECC-checks the 32-bit packet header.
- Sequences long-packet payload and footer, and emits frame/line framing pulses, counters and a 16-bit payload stream for the pixel unpacker and frame-buffer address generator.

Parameters:
- SYNC_BYTE, 8'hB8, HS leader byte expected on both lanes.
- MAX_WC, 16'd8192, largest accepted long-packet word count; larger values are an error.
- PIX_DT_MIN, 6'h18, lowest data type counted as an image line.

Ports:
- byte_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- cfg_enable  in  1  accept new packets; sampled only in HUNT.
- byte_valid  in  1  both lanes in HS, bytes valid this cycle.
- lane0_byte  in  8  deserialized lane-0 byte.
- lane1_byte  in  8  deserialized lane-1 byte.
- payload_data  out  16  {lane1,lane0} payload bytes.
- payload_keep  out  2  byte enables; 2'b11 full beat, 2'b01 lane0 only.
- payload_valid  out  1  payload beat valid.
- payload_last  out  1  final beat of the packet.
- pkt_dt  out  6  data type of the current/last accepted packet.
- pkt_wc  out  16  word count of the current/last accepted long packet.
- frame_start  out  1  1-cycle pulse on a valid FS (DT 0x00).
- frame_end  out  1  1-cycle pulse on a valid FE (DT 0x01).
- line_start  out  1  1-cycle pulse coincident with the first payload beat of a DT>=PIX_DT_MIN packet.
- line_count  out  16  image lines in the current frame.
- frame_count  out  16  completed frames (FE count), wraps.
- ecc_err  out  1  1-cycle pulse on header ECC mismatch.
- sync_err  out  1  1-cycle pulse when only one lane shows SYNC_BYTE.
- trunc_err  out  1  1-cycle pulse when byte_valid drops in PAYLOAD/FOOTER, or when WC>MAX_WC.

Behaviour:
- Reset (synchronous): state=HUNT; every output 0, including counters, pkt_dt and pkt_wc.
- Lane byte order: byte n is on lane (n mod 2).
  - Header cycle A: lane0=DI, lane1=WC[7:0].
  - Header cycle B: lane0=WC[15:8], lane1=ECC.
- ECC: 6-bit CSI-2 Hamming over D[23:0]={WC_hi,WC_lo,DI}, ECC[7:6] must be 0. Mismatch means the packet is discarded with no correction.
- All outputs are registered: each response appears 1 cycle after the sampled input cycle.
- States:
  - HUNT:
    - if cfg_enable & byte_valid & both lanes==SYNC_BYTE -> HDR_A.
    - if exactly one lane==SYNC_BYTE -> sync_err, WAIT_EOT.
  - HDR_A: capture DI and WC_lo -> HDR_B.
  - HDR_B: form header and check ECC.
    - Mismatch -> ecc_err, WAIT_EOT.
    - DI[5:0]<0x10 (short packet): update pkt_dt. DT 0x00 -> frame_start, line_count:=0. DT 0x01 -> frame_end, frame_count+1. Then -> WAIT_EOT.
    - Long packet, WC>MAX_WC -> trunc_err, WAIT_EOT.
    - Long packet, WC==0 -> FOOTER.
    - Otherwise -> PAYLOAD, remaining:=WC; pkt_dt and pkt_wc updated.
  - PAYLOAD: each byte_valid cycle emits one beat.
    - remaining>=2: keep=11, remaining-=2.
    - remaining==1: keep=01, and lane1 of that beat is CRC_lo.
    - payload_last when remaining<=2; then -> FOOTER.
  - FOOTER: consume 1 cycle (CRC bytes, not checked).
    - If DT>=PIX_DT_MIN, line_count+1 (saturates at 16'hFFFF).
    - -> WAIT_EOT.
  - WAIT_EOT: stay until byte_valid==0 -> HUNT.
- byte_valid low in PAYLOAD or FOOTER: trunc_err; no payload_last; no line_count increment; -> HUNT immediately.
- byte_valid low in HDR_A or HDR_B: -> HUNT silently.
- line_start pulses only on the first PAYLOAD beat.
- Second FS without FE: line_count:=0; frame_count unchanged.
- cfg_enable deasserted mid-packet: the current packet completes normally; no new sync is accepted afterwards.
- Reset asserted in any state: HUNT on the next edge; pulses and payload_valid are low that cycle.

Test Plan:
- FS: sync B8/B8, then (00,00), then (00,00), then byte_valid low -> frame_start 1 cycle; line_count=0; no payload_valid.
- FE: (01,00),(00,07) -> frame_end pulse; frame_count 0->1. Repeat with ECC byte 0x06 -> ecc_err pulse, frame_count unchanged.
- RAW10, DT 0x2B, WC=5, golden ECC from the bench model:
  - Beats: keep 11, 11, 01, with payload_last on beat 3.
  - line_start on beat 1; 1 footer cycle; line_count +1.
- RAW8 DT 0x2A with WC=4 -> 2 full beats, payload_last on beat 2, footer cycle, line_count +1.
- WC=9000 -> trunc_err, no payload. Then valid WC=6 with byte_valid dropped after beat 1 -> trunc_err, no payload_last, line_count unchanged.
- Lane0=B8, lane1=00 -> sync_err; bytes ignored until byte_valid low. Then a synchronous reset asserted mid-PAYLOAD -> all outputs 0 next edge, state HUNT, and the next clean FS is accepted.
